serial_packet_transmitter: RTL and testbench

- Serial packet forwarder.
- A one-cycle `start` pulse arms the block.
- It then captures a length header of LEN_W bits from serial input `RcIn`, MSB first.
- It then forwards exactly that many following `RcIn` bits to `txOut`, with `txValid` qualifying each bit.
- An `abort` pulse cancels a packet in flight and is reported on `txAbort`.
- Sits between a serial receive line and a downstream serial consumer.

---
 rtl/serial_packet_transmitter.sv | 89 ++++++++
 tb/tb_serial_packet_transmitter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_transmitter.sv
// serial_packet_transmitter: arms on start, captures an LEN_W-bit length header
// from RcIn (MSB first), then forwards that many RcIn bits to txOut.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low
//   RcIn      serial data in
//   start     packet start request (accepted only while idle)
//   abort     cancels a packet in flight (ignored while idle)
//   txOut     forwarded payload bit, holds its last value when not valid
//   txValid   qualifies txOut
//   txAbort   one-cycle pulse after an in-flight packet is aborted
//   startSeen high while header or payload is being processed
module serial_packet_transmitter #(
    parameter int LEN_W = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic RcIn,
    input  logic start,
    input  logic abort,
    output logic txOut,
    output logic txValid,
    output logic txAbort,
    output logic startSeen
);
    localparam logic [LEN_W-1:0] LAST_BIT = LEN_W'(LEN_W - 1);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] rem_cnt;
    logic [LEN_W-1:0] len_next;
    // length as it stands once the bit sampled at this edge is shifted in
    assign len_next = {len_q[LEN_W-2:0], RcIn};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            bit_cnt   <= '0;
            rem_cnt   <= '0;
            txOut     <= 1'b0;
            txValid   <= 1'b0;
            txAbort   <= 1'b0;
            startSeen <= 1'b0;
        end else begin
            txValid <= 1'b0;
            txAbort <= 1'b0;
            if (state != IDLE && abort) begin
                state     <= IDLE;
                startSeen <= 1'b0;
                txAbort   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= HEADER;
                            bit_cnt   <= '0;
                            startSeen <= 1'b1;
                        end
                    end
                    HEADER: begin
                        len_q   <= len_next;
                        bit_cnt <= bit_cnt + ONE;
                        if (bit_cnt == LAST_BIT) begin
                            if (len_next == '0) begin
                                state     <= IDLE;
                                startSeen <= 1'b0;
                            end else begin
                                state   <= PAYLOAD;
                                rem_cnt <= len_next;
                            end
                        end
                    end
                    PAYLOAD: begin
                        txOut   <= RcIn;
                        txValid <= 1'b1;
                        rem_cnt <= rem_cnt - ONE;
                        if (rem_cnt == ONE) begin
                            state     <= IDLE;
                            startSeen <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_packet_transmitter.sv
// tb_serial_packet_transmitter: directed and random packets against a packet-level reference model
module tb_serial_packet_transmitter;
    localparam int LEN_W = 7;
    localparam int MAXL  = 512;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic RcIn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic txOut, txValid, txAbort, startSeen;
    int n_chk = 0;
    int n_fail = 0;
    int vcount;
    bit tx_hold = 1'b0;
    bit st[MAXL], ab[MAXL], rc[MAXL];
    bit e_ss[MAXL], e_v[MAXL], e_o[MAXL], e_a[MAXL];

    serial_packet_transmitter #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .RcIn(RcIn), .start(start), .abort(abort),
        .txOut(txOut), .txValid(txValid), .txAbort(txAbort), .startSeen(startSeen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".txOut"}, txOut, 1'b0);
        chk({tag, ".txValid"}, txValid, 1'b0);
        chk({tag, ".txAbort"}, txAbort, 1'b0);
        chk({tag, ".startSeen"}, startSeen, 1'b0);
    endtask

    task automatic clear_stim();
        foreach (st[i]) begin
            st[i] = 1'b0;
            ab[i] = 1'b0;
            rc[i] = 1'b0;
        end
    endtask

    task automatic rand_rc(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) rc[i] = bit'($urandom_range(0, 1));
    endtask

    task automatic put_header(input int k0, input int n);
        for (int i = 1; i <= LEN_W; i++) rc[k0 + i] = bit'((n >> (LEN_W - i)) & 1);
    endtask

    // Packet-level model: edge k0 accepts a start while free, header occupies
    // the next LEN_W edges, payload the N after that; the first abort inside
    // the packet ends it early. Index j means "outputs after edge j".
    task automatic build(input int len);
        int k;
        bit o;
        for (int j = 0; j < MAXL; j++) begin
            e_ss[j] = 1'b0;
            e_v[j]  = 1'b0;
            e_a[j]  = 1'b0;
        end
        k = 0;
        while (k < len) begin
            if (!st[k]) begin
                k++;
            end else begin
                int n, e, fin;
                bit hit;
                n = 0;
                for (int i = 1; i <= LEN_W; i++) n = n * 2 + int'(rc[k + i]);
                e = k + LEN_W + n;
                fin = e;
                hit = 1'b0;
                for (int a = k + 1; a <= e && !hit; a++)
                    if (ab[a]) begin
                        fin = a;
                        hit = 1'b1;
                    end
                for (int j = k; j < fin; j++) e_ss[j] = 1'b1;
                if (hit) e_a[fin] = 1'b1;
                for (int j = k + LEN_W + 1; j <= e; j++)
                    if (!hit || j < fin) e_v[j] = 1'b1;
                k = fin + 1;
            end
        end
        o = tx_hold;
        for (int j = 0; j < len; j++) begin
            if (e_v[j]) o = rc[j];
            e_o[j] = o;
        end
        tx_hold = o;
    endtask

    task automatic run(input string name, input int len);
        build(len);
        vcount = 0;
        for (int j = 0; j < len; j++) begin
            start = st[j];
            abort = ab[j];
            RcIn  = rc[j];
            @(posedge clk);
            #1;
            vcount += int'(txValid);
            chk($sformatf("%s[%0d].txValid", name, j), txValid, e_v[j]);
            chk($sformatf("%s[%0d].txOut", name, j), txOut, e_o[j]);
            chk($sformatf("%s[%0d].txAbort", name, j), txAbort, e_a[j]);
            chk($sformatf("%s[%0d].startSeen", name, j), startSeen, e_ss[j]);
        end
        start = 1'b0;
        abort = 1'b0;
        RcIn  = 1'b0;
    endtask

    initial begin
        // reset held with start/abort toggling
        start = 1'b1;
        #1;
        chk_idle("rst_async");
        @(posedge clk);
        #1;
        chk_idle("rst_c0");
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("rst_c1");
        abort = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_idle($sformatf("post_rst[%0d]", i));
        end

        // normal N=5 packet
        clear_stim();
        st[0] = 1'b1;
        put_header(0, 5);
        rc[8] = 1'b1; rc[9] = 1'b0; rc[10] = 1'b1; rc[11] = 1'b1; rc[12] = 1'b0;
        run("normal", 20);
        chk_int("normal.nvalid", vcount, 5);

        // zero length header
        clear_stim();
        rand_rc(8, 15);
        st[0] = 1'b1;
        put_header(0, 0);
        run("zero", 16);
        chk_int("zero.nvalid", vcount, 0);

        // abort after 3 payload bits, then a fresh N=3 packet
        clear_stim();
        rand_rc(0, 34);
        st[0] = 1'b1;
        put_header(0, 20);
        ab[11] = 1'b1;
        st[14] = 1'b1;
        put_header(14, 3);
        run("abort", 35);
        chk_int("abort.nvalid", vcount, 6);

        // abort while idle, start while busy
        clear_stim();
        rand_rc(0, 29);
        ab[0] = 1'b1;
        st[2] = 1'b1;
        put_header(2, 10);
        st[13] = 1'b1;
        run("busy", 30);
        chk_int("busy.nvalid", vcount, 10);

        // long random packet, header 1011010
        clear_stim();
        rand_rc(0, 109);
        st[0] = 1'b1;
        put_header(0, 90);
        run("long", 110);
        chk_int("long.nvalid", vcount, 90);

        // random soup of starts, aborts and data, padded so it drains to idle
        clear_stim();
        rand_rc(0, 399);
        for (int j = 0; j < 200; j++) begin
            st[j] = ($urandom_range(0, 15) == 0);
            ab[j] = ($urandom_range(0, 39) == 0);
        end
        run("soup", 400);

        // reset in the middle of a payload
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        RcIn  = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid.pre_rst.txValid", txValid, 1'b1);
        chk("mid.pre_rst.startSeen", startSeen, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("mid.rst");
        @(posedge clk);
        #1;
        chk_idle("mid.rst_edge");
        rst = 1'b1;
        RcIn = 1'b0;
        tx_hold = 1'b0;

        // recovery after reset
        clear_stim();
        rand_rc(8, 14);
        st[0] = 1'b1;
        put_header(0, 3);
        run("recover", 15);
        chk_int("recover.nvalid", vcount, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
